pixel_window_ctrl: RTL and testbench
====================================

Name: pixel_window_ctrl

Overview:
- Upstream stage of the Harris window pipeline. Accepts a raster pixel stream, one 8-bit pixel per cycle.
- Stores the stream round-robin in WIN+1 internal line stores. Once WIN full lines are present, it scans out one WIN x WIN pixel window per cycle, left to right.
- Feeds the gradient/Sobel stage. Pulses an interrupt after each consumed row so the DMA/source can send another line.

Parameters:
- DATA_W, 8, pixel width in bits
- LINE_W, 480, pixels per image line
- WIN, 6, window height and width
- (derived) OUT_PER_ROW = LINE_W-WIN+1 (475); CNT_W = $clog2((WIN+1)*LINE_W+1) (12)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_pix  in  DATA_W  input pixel
- i_pix_valid  in  1  pixel present this cycle
- o_pix_ready  out  1  block can accept a pixel this cycle
- o_window  out  WIN*WIN*DATA_W  window; element (r,c) at [(r*WIN+c)*DATA_W +: DATA_W]; r=0 is the oldest line, c=0 is the leftmost column
- o_window_valid  out  1  o_window holds a new window this cycle
- o_row_done  out  1  one-cycle pulse after the last window of a row
- i_win_ready  in  1  downstream accepts a window (present only with WINDOW_STALL_EN)

Behaviour:
- Reset values: all outputs 0 except o_pix_ready=1; all pointers and counters 0; FSM in IDLE. Line-store contents are not reset.
- Write side:
  - Pixel is accepted when i_pix_valid && o_pix_ready and written to wr_line[wr_col].
  - wr_col wraps from LINE_W-1 to 0; on that wrap, wr_line advances mod WIN+1.
- Occupancy: pix_cnt is +1 per accepted pixel and -LINE_W on the row-done cycle. Both apply in the same cycle when they coincide (net +1-LINE_W).
- o_pix_ready = (pix_cnt < (WIN+1)*LINE_W). Combinational; deasserts the cycle the count reaches 3360. A pixel presented while ready=0 is not written; the source holds it.
- FSM:
  - IDLE -> SCAN when pix_cnt >= WIN*LINE_W.
  - SCAN: rd_col steps 0..OUT_PER_ROW-1, one step per advance cycle.
  - After rd_col = OUT_PER_ROW-1: pulse o_row_done, pix_cnt -= LINE_W, rd_base advances mod WIN+1, go to IDLE.
  - IDLE may re-enter SCAN on the next cycle if occupancy allows, giving one bubble cycle minimum between rows.
- Read side: the window row r comes from line (rd_base+r) mod (WIN+1), columns rd_col..rd_col+WIN-1. Registered output, so o_window/o_window_valid appear 1 cycle after the advance cycle.
- The write line is never one of the WIN lines being scanned; occupancy gating guarantees this.
- o_row_done is asserted in the same cycle as the last o_window_valid of the row.
- Reset mid-scan: FSM to IDLE, counts cleared, o_window_valid=0 the next cycle, partial row discarded.
- No end-of-frame handling: the source flushes by streaming whole lines.

Optional Feature:
- WINDOW_STALL_EN defined:
  - i_win_ready exists. An advance occurs only when i_win_ready=1.
  - While o_window_valid=1 and i_win_ready=0, o_window and o_window_valid hold stable.
- Undefined: the port is absent and the scan advances every SCAN cycle unconditionally.

Decomposition:
- Package harris_pkg: DATA_W, LINE_W, WIN, OUT_PER_ROW, CNT_W constants; the FSM state typedef (IDLE, SCAN).
- One sub-module, pixel_line_store: a single LINE_W x DATA_W store with a write port and WIN parallel combinational reads from a base column. Instantiated WIN+1 times.

Test Plan:
- Stream 6x480 pixels with value=(line*7+col)%256 -> SCAN starts; first window valid 2 cycles after the 2880th pixel; window (0,0)=0, (5,5)=(35+5)%256=40; 475 valid windows; o_row_done on the 475th.
- Continuous 10-line stream, i_pix_valid held high -> o_pix_ready drops when pix_cnt=3360; rows 2..5 window contents match the golden model; no pixel is lost.
- Pixel accepted on the same cycle as o_row_done -> pix_cnt = prev+1-480; the next scan uses the correct rd_base (1).
- i_rst asserted at rd_col=100 -> next cycle o_window_valid=0, o_pix_ready=1, pix_cnt=0; a new 6-line fill reproduces the first-row results.
- With WINDOW_STALL_EN, toggle i_win_ready 1,0,0,1 -> o_window held over the stall cycles; still 475 windows per row, in order.

Source files
------------

// File: rtl/harris_pkg.sv
// Shared constants and types for the Harris window front end.
// Geometry is fixed here so every stage of the pipeline agrees on it.
package harris_pkg;

  localparam int DATA_W      = 8;
  localparam int LINE_W      = 480;
  localparam int WIN         = 6;
  localparam int OUT_PER_ROW = LINE_W - WIN + 1;
  localparam int CNT_W       = $clog2((WIN + 1) * LINE_W + 1);
  localparam int COL_W       = $clog2(LINE_W);
  localparam int LINE_IDX_W  = $clog2(WIN + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'((WIN + 1) * LINE_W);
  localparam logic [CNT_W-1:0] CNT_SCAN = CNT_W'(WIN * LINE_W);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Line-store index arithmetic modulo WIN+1.
  function automatic logic [LINE_IDX_W-1:0] line_add(input logic [LINE_IDX_W-1:0] base,
                                                     input int unsigned           off);
    int unsigned sum;
    sum = 32'(base) + off;
    return LINE_IDX_W'(sum % (WIN + 1));
  endfunction

endpackage

// File: rtl/pixel_line_store.sv
// One raster line of pixels: single write port, WIN adjacent
// combinational reads starting at a base column.
module pixel_line_store
  import harris_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       wr_en,
  input  logic [COL_W-1:0]           wr_col,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [COL_W-1:0]           rd_base,
  output logic [WIN-1:0][DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [LINE_W];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_col] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < WIN; k++) rd_data[k] = mem[rd_base + COL_W'(k)];
  end

endmodule

// File: rtl/pixel_window_ctrl.sv
// Harris window front end: buffers WIN+1 raster lines and scans WIN x WIN windows.
// Define WINDOW_STALL_EN to add i_win_ready backpressure on the window output.
module pixel_window_ctrl
  import harris_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_W-1:0]         i_pix,
  input  logic                      i_pix_valid,
`ifdef WINDOW_STALL_EN
  input  logic                      i_win_ready,
`endif
  output logic                      o_pix_ready,
  output logic [WIN*WIN*DATA_W-1:0] o_window,
  output logic                      o_window_valid,
  output logic                      o_row_done
);

  // state | meaning
  // IDLE  | waiting until WIN full lines are buffered
  // SCAN  | stepping rd_col across one row of windows

  scan_state_t               state_q, state_d;
  logic [COL_W-1:0]          wr_col, rd_col;
  logic [LINE_IDX_W-1:0]     wr_line, rd_base;
  logic [CNT_W-1:0]          pix_cnt;
  logic                      accept, adv_ok, advance, last_adv, hold;
  logic [WIN-1:0][DATA_W-1:0] line_rd [WIN+1];
  logic [WIN*WIN*DATA_W-1:0] window_next;

  assign o_pix_ready = (pix_cnt < CNT_FULL);
  assign accept      = i_pix_valid && o_pix_ready;

`ifdef WINDOW_STALL_EN
  assign adv_ok = i_win_ready;
  assign hold   = o_window_valid && !i_win_ready;
`else
  assign adv_ok = 1'b1;
  assign hold   = 1'b0;
`endif

  assign advance  = (state_q == SCAN) && adv_ok;
  assign last_adv = advance && (rd_col == COL_W'(OUT_PER_ROW - 1));

  for (genvar g = 0; g < WIN + 1; g++) begin : g_line
    pixel_line_store u_line (
      .i_clk   (i_clk),
      .wr_en   (accept && (wr_line == LINE_IDX_W'(g))),
      .wr_col  (wr_col),
      .wr_data (i_pix),
      .rd_base (rd_col),
      .rd_data (line_rd[g])
    );
  end

  // Window row r is taken from the line r positions after the oldest one.
  always_comb begin
    window_next = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        window_next[(r*WIN+c)*DATA_W +: DATA_W] = line_rd[line_add(rd_base, r)][c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pix_cnt >= CNT_SCAN) state_d = SCAN;
      SCAN:    if (last_adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      wr_col         <= '0;
      wr_line        <= '0;
      rd_col         <= '0;
      rd_base        <= '0;
      pix_cnt        <= '0;
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_row_done     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (wr_col == COL_W'(LINE_W - 1)) begin
          wr_col  <= '0;
          wr_line <= line_add(wr_line, 1);
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      // Fill and drain can land in the same cycle; both apply.
      pix_cnt <= pix_cnt + CNT_W'(accept) - (last_adv ? CNT_W'(LINE_W) : '0);
      if (advance) begin
        o_window       <= window_next;
        o_window_valid <= 1'b1;
        rd_col         <= last_adv ? '0 : rd_col + 1'b1;
        if (last_adv) rd_base <= line_add(rd_base, 1);
      end else if (!hold) begin
        o_window_valid <= 1'b0;
      end
      o_row_done <= last_adv;
    end
  end

endmodule

// File: tb/tb_pixel_window_ctrl.sv
// Directed bench for pixel_window_ctrl: probe table on captured windows plus
// hand sequences for row overlap, mid-scan reset and (optionally) stalls.
module tb_pixel_window_ctrl;
  import harris_pkg::*;

  localparam int WW       = WIN * WIN * DATA_W;
  localparam int MAX_ROWS = 10;
  localparam int N_PROBES = 13;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [DATA_W-1:0] i_pix;
  logic              i_pix_valid;
`ifdef WINDOW_STALL_EN
  logic              i_win_ready;
`endif
  logic              o_pix_ready;
  logic [WW-1:0]     o_window;
  logic              o_window_valid;
  logic              o_row_done;

  pixel_window_ctrl dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pix          (i_pix),
    .i_pix_valid    (i_pix_valid),
`ifdef WINDOW_STALL_EN
    .i_win_ready    (i_win_ready),
`endif
    .o_pix_ready    (o_pix_ready),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .o_row_done     (o_row_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix_val(input int line, input int col);
    return DATA_W'((line * 7 + col) % 256);
  endfunction

  function automatic logic [WW-1:0] model_win(input int line0, input int col);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        w[(r*WIN+c)*DATA_W +: DATA_W] = pix_val(line0 + r, col + c);
    return w;
  endfunction

  // Window monitor: samples mid-cycle, after the driver has settled inputs.
  int            mon_row = 0;
  int            mon_col = 0;
  bit            mon_clear = 1'b0;
  bit            seen_first = 1'b0;
  int            first_valid_cyc = 0;
  int            cnt_at_done [MAX_ROWS];
  logic [WW-1:0] cap [MAX_ROWS][OUT_PER_ROW];
  logic          consume;

  always begin
    @(negedge i_clk);
    #2;
`ifdef WINDOW_STALL_EN
    consume = o_window_valid && i_win_ready;
`else
    consume = o_window_valid;
`endif
    if (mon_clear) begin
      mon_row    = 0;
      mon_col    = 0;
      seen_first = 1'b0;
      mon_clear  = 1'b0;
    end else if (consume) begin
      if (!seen_first) begin
        seen_first      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (mon_row < MAX_ROWS && mon_col < OUT_PER_ROW) cap[mon_row][mon_col] = o_window;
      if (o_row_done) begin
        chk("row_done_col", mon_col, OUT_PER_ROW - 1);
        if (mon_row < MAX_ROWS) cnt_at_done[mon_row] = int'(dut.pix_cnt);
        mon_row++;
        mon_col = 0;
      end else begin
        mon_col++;
      end
    end else if (o_row_done) begin
      chk("row_done_with_valid", int'(o_window_valid), 1);
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  int last_acc_cyc = 0;

  task automatic push_pix(input int line, input int col);
    int guard;
    guard       = 0;
    i_pix       = pix_val(line, col);
    i_pix_valid = 1'b1;
    while (!o_pix_ready) begin
      tick();
      guard++;
      if (guard > 4000) begin
        $display("FAIL push_timeout line=%0d col=%0d", line, col);
        errors++;
        $fatal(1, "push stalled");
      end
    end
    last_acc_cyc = cyc + 1;
    tick();
  endtask

  task automatic push_line(input int line);
    for (int col = 0; col < LINE_W; col++) push_pix(line, col);
  endtask

  task automatic wait_rows(input int n, input int budget, input string name);
    int g;
    g = 0;
    while (mon_row < n && g < budget) begin
      tick();
      g++;
    end
    chk(name, mon_row, n);
  endtask

  task automatic check_row(input int row, input int line0, input string name);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int col = 0; col < OUT_PER_ROW; col++) begin
      if (cap[row][col] !== model_win(line0, col)) begin
        bad++;
        if (first < 0) first = col;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s row=%0d bad_windows=%0d first_col=%0d got=%h want=%h",
               name, row, bad, first, cap[row][first], model_win(line0, first));
    end
  endtask

  typedef struct {
    int row;
    int col;
    int r;
    int c;
    int exp;
  } probe_t;

  probe_t        probes [N_PROBES];
  logic [WW-1:0] probe_w;
  int            acc_ref;
  int            g;

  initial begin
    probes[0]  = '{0,   0, 0, 0,   0};
    probes[1]  = '{0,   0, 5, 5,  40};
    probes[2]  = '{0,   0, 0, 5,   5};
    probes[3]  = '{0,   0, 5, 0,  35};
    probes[4]  = '{0, 474, 0, 0, 218};
    probes[5]  = '{0, 474, 5, 5,   2};
    probes[6]  = '{0, 100, 2, 3, 117};
    probes[7]  = '{1,   0, 0, 0,   7};
    probes[8]  = '{1,   0, 5, 5,  47};
    probes[9]  = '{2, 255, 1, 4,  24};
    probes[10] = '{3, 474, 5, 5,  23};
    probes[11] = '{4, 200, 5, 0,   7};
    probes[12] = '{4,   0, 0, 5,  33};

    i_rst       = 1'b1;
    i_pix       = '0;
    i_pix_valid = 1'b0;
`ifdef WINDOW_STALL_EN
    i_win_ready = 1'b1;
`endif
    tick();
    tick();
    i_rst     = 1'b0;
    mon_clear = 1'b1;
    tick();
    chk("reset_pix_ready", int'(o_pix_ready), 1);
    chk("reset_window_valid", int'(o_window_valid), 0);
    chk("reset_row_done", int'(o_row_done), 0);
    chk("reset_window_nonzero", int'(o_window != '0), 0);
    chk("reset_pix_cnt", int'(dut.pix_cnt), 0);

    // Continuous 10-line stream: rows 0..4, each drain overlaps a fill.
    acc_ref = 0;
    for (int line = 0; line < 10; line++) begin
      push_line(line);
      if (line == WIN - 1) acc_ref = last_acc_cyc;
    end
    i_pix_valid = 1'b0;
    wait_rows(5, 3000, "stream_rows_done");
    chk("first_window_latency", first_valid_cyc - acc_ref, 2);
    chk("stream_end_pix_cnt", int'(dut.pix_cnt), 2400);
    chk("stream_end_pix_ready", int'(o_pix_ready), 1);
    for (int k = 0; k < 4; k++) chk($sformatf("overlap_cnt_row%0d", k), cnt_at_done[k], 2876);
    chk("last_row_cnt", cnt_at_done[4], 2400);
    for (int k = 0; k < 5; k++) check_row(k, k, "stream_row_model");
    for (int i = 0; i < N_PROBES; i++) begin
      probe_w = cap[probes[i].row][probes[i].col];
      chk($sformatf("probe%0d_row%0d_col%0d_r%0d_c%0d", i, probes[i].row, probes[i].col,
                    probes[i].r, probes[i].c),
          int'(probe_w[(probes[i].r*WIN+probes[i].c)*DATA_W +: DATA_W]), probes[i].exp);
    end

    // Reset in the middle of a scan, then refill and rescan.
    i_rst     = 1'b1;
    mon_clear = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int line = 0; line < WIN; line++) push_line(line);
    i_pix_valid = 1'b0;
    g = 0;
    while (mon_col < 100 && g < 1000) begin
      tick();
      g++;
    end
    chk("reach_col100", mon_col, 100);
    i_rst     = 1'b1;
    mon_clear = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midreset_window_valid", int'(o_window_valid), 0);
    chk("midreset_pix_ready", int'(o_pix_ready), 1);
    chk("midreset_pix_cnt", int'(dut.pix_cnt), 0);
    chk("midreset_row_done", int'(o_row_done), 0);
    for (int line = 0; line < WIN; line++) begin
      push_line(line);
      if (line == WIN - 1) acc_ref = last_acc_cyc;
    end
    i_pix_valid = 1'b0;
    wait_rows(1, 1500, "refill_row_done");
    chk("refill_latency", first_valid_cyc - acc_ref, 2);
    check_row(0, 0, "refill_row_model");
    chk("refill_pix_cnt", int'(dut.pix_cnt), 2400);

`ifdef WINDOW_STALL_EN
    // Fill to capacity with the consumer stalled, then toggle ready 1,0,0,1.
    i_rst       = 1'b1;
    i_win_ready = 1'b0;
    mon_clear   = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int line = 0; line < WIN + 1; line++) push_line(line);
    i_pix       = pix_val(WIN + 1, 0);
    i_pix_valid = 1'b1;
    chk("full_pix_ready", int'(o_pix_ready), 0);
    chk("full_pix_cnt", int'(dut.pix_cnt), 3360);
    tick();
    tick();
    chk("full_no_accept", int'(dut.pix_cnt), 3360);
    chk("full_no_window", int'(o_window_valid), 0);
    i_win_ready = 1'b1;
    tick();
    i_win_ready = 1'b0;
    chk("stall_valid_a", int'(o_window_valid), 1);
    chk("stall_window_a", int'(o_window == model_win(0, 0)), 1);
    tick();
    chk("stall_valid_b", int'(o_window_valid), 1);
    chk("stall_window_b", int'(o_window == model_win(0, 0)), 1);
    tick();
    chk("stall_valid_c", int'(o_window_valid), 1);
    chk("stall_window_c", int'(o_window == model_win(0, 0)), 1);
    i_win_ready = 1'b1;
    push_line(WIN + 1);
    push_line(WIN + 2);
    i_pix_valid = 1'b0;
    wait_rows(4, 3000, "stall_rows_done");
    for (int k = 0; k < 4; k++) check_row(k, k, "stall_row_model");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
